// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave terminating in a bank of memory-mapped registers.
// Registers flagged in RO_MASK read from ro_in and reject writes with SLVERR.
module axi_lite_regfile_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NUM_REGS * STRB_WIDTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
    logic [DATA_WIDTH-1:0] ro_arr [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_map
        assign ro_arr[i] = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
    end

    // ---------------- write path ----------------
    logic                  aw_held, w_held, bvalid_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic [1:0]            bresp_q;
    logic                  aw_hs, w_hs, commit, wr_ok;
    logic [IDX_W-1:0]      wr_idx;

    assign AWREADY = !aw_held && !bvalid_q;
    assign WREADY  = !w_held && !bvalid_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign commit = aw_held && w_held;
    assign wr_idx = aw_addr_q[LSB +: IDX_W];
    assign wr_ok  = ({1'b0, aw_addr_q} < LIMIT) && !RO_MASK[wr_idx];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            wr_pulse  <= '0;
        end else begin
            wr_pulse <= '0;
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            // ready is low while a response is pending, so commit and B handshake never overlap
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) begin
                    wr_pulse[wr_idx] <= 1'b1;
                end
            end else if (bvalid_q && BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && wr_ok) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
                if (w_strb_q[k]) begin
                    regs[wr_idx][k*8 +: 8] <= w_data_q[k*8 +: 8];
                end
            end
        end
    end

    // ---------------- read path ----------------
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;

    assign ARREADY     = !rvalid_q;
    assign RVALID      = rvalid_q;
    assign RDATA       = rdata_q;
    assign RRESP       = rresp_q;
    assign rd_idx      = ARADDR[LSB +: IDX_W];
    assign rd_in_range = {1'b0, ARADDR} < LIMIT;

    // regs is sampled before any same-edge commit lands, so reads see the old value
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ARVALID && ARREADY) begin
            rvalid_q <= 1'b1;
            if (!rd_in_range) begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end else begin
                rdata_q <= RO_MASK[rd_idx] ? ro_arr[rd_idx] : regs[rd_idx];
                rresp_q <= RESP_OKAY;
            end
        end else if (rvalid_q && RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave with a transaction-level register model
// compared against the DUT outputs on every falling clock edge.
module tb_axi_lite_regfile_slave;
    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic [31:0]  AWADDR = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [31:0]  ARADDR = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [511:0] reg_out;
    logic [511:0] ro_in = '0;
    logic [15:0]  wr_pulse;

    localparam logic [31:0] RO_VAL = 32'h1234_5678;

    axi_lite_regfile_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .RO_MASK(16'h0004)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    task chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [16] = '{default: 32'h0};
    logic        aw_pend = 1'b0, w_pend = 1'b0;
    logic [31:0] m_awaddr = '0, m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic        m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = '0, m_rresp = '0;
    logic [31:0] m_rdata = '0;
    logic [15:0] m_pulse = '0;

    always @(posedge ACLK or negedge ARESETn) begin
        logic aw_hs, w_hs, ar_hs;
        int   idx;
        if (!ARESETn) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            aw_pend = 0; w_pend = 0; m_bvalid = 0; m_rvalid = 0;
            m_bresp = 0; m_rresp = 0; m_rdata = 0; m_pulse = 0;
        end else begin
            aw_hs = AWVALID && !aw_pend && !m_bvalid;
            w_hs  = WVALID && !w_pend && !m_bvalid;
            ar_hs = ARVALID && !m_rvalid;
            // read sees the register bank as it was before this edge
            if (m_rvalid && RREADY) m_rvalid = 0;
            if (ar_hs) begin
                m_rvalid = 1;
                if (ARADDR >= 32'd64) begin
                    m_rdata = 0; m_rresp = 2'b10;
                end else begin
                    idx = int'(ARADDR / 4);
                    m_rdata = (idx == 2) ? RO_VAL : m_regs[idx];
                    m_rresp = 2'b00;
                end
            end
            m_pulse = 0;
            if (m_bvalid && BREADY) m_bvalid = 0;
            if (aw_pend && w_pend) begin
                aw_pend = 0; w_pend = 0; m_bvalid = 1;
                idx = int'(m_awaddr / 4);
                if (m_awaddr < 32'd64 && idx != 2) begin
                    for (int k = 0; k < 4; k++)
                        if (m_wstrb[k]) m_regs[idx][k*8 +: 8] = m_wdata[k*8 +: 8];
                    m_bresp = 2'b00;
                    m_pulse = 16'(1) << idx;
                end else begin
                    m_bresp = 2'b10;
                end
            end
            if (aw_hs) begin aw_pend = 1; m_awaddr = AWADDR; end
            if (w_hs)  begin w_pend = 1; m_wdata = WDATA; m_wstrb = WSTRB; end
        end
    end

    // ---------------- per-cycle compare ----------------
    int pulse_cnt [16] = '{default: 0};

    always @(negedge ACLK) begin
        if (ARESETn) begin
            chk("awready", AWREADY, !aw_pend && !m_bvalid);
            chk("wready", WREADY, !w_pend && !m_bvalid);
            chk("arready", ARREADY, !m_rvalid);
            chk("bvalid", BVALID, m_bvalid);
            if (m_bvalid) chk("bresp", BRESP, m_bresp);
            chk("rvalid", RVALID, m_rvalid);
            if (m_rvalid) begin
                chk("rdata", RDATA, m_rdata);
                chk("rresp", RRESP, m_rresp);
            end
            chk("wr_pulse", wr_pulse, m_pulse);
            for (int i = 0; i < 16; i++)
                chk($sformatf("reg_out[%0d]", i), reg_out[i*32 +: 32], (i == 2) ? 32'h0 : m_regs[i]);
        end
        for (int i = 0; i < 16; i++) if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;
    end

    // ---------------- channel drivers (called just after a falling edge) ----------------
    task automatic send_aw(input logic [31:0] a);
        AWADDR = a; AWVALID = 1;
        for (int i = 0; i < 64 && !AWREADY; i++) @(negedge ACLK);
        chk("aw_accept", AWREADY, 1);
        @(negedge ACLK);
        AWVALID = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        WDATA = d; WSTRB = s; WVALID = 1;
        for (int i = 0; i < 64 && !WREADY; i++) @(negedge ACLK);
        chk("w_accept", WREADY, 1);
        @(negedge ACLK);
        WVALID = 0;
    endtask

    task automatic wait_b(output logic [1:0] r);
        BREADY = 1;
        for (int i = 0; i < 64 && !BVALID; i++) @(negedge ACLK);
        chk("b_arrive", BVALID, 1);
        r = BRESP;
        @(negedge ACLK);
        BREADY = 0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        ARADDR = a; ARVALID = 1;
        for (int i = 0; i < 64 && !ARREADY; i++) @(negedge ACLK);
        chk("ar_accept", ARREADY, 1);
        @(negedge ACLK);
        ARVALID = 0;
    endtask

    task automatic wait_r(output logic [31:0] d, output logic [1:0] r);
        RREADY = 1;
        for (int i = 0; i < 64 && !RVALID; i++) @(negedge ACLK);
        chk("r_arrive", RVALID, 1);
        d = RDATA; r = RRESP;
        @(negedge ACLK);
        RREADY = 0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_b(r);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        send_ar(a);
        wait_r(d, r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] bsave, rsave;
        int          pc;

        for (int i = 0; i < 16; i++) ro_in[i*32 +: 32] = 32'hBAD0_0000 + 32'(i);
        ro_in[2*32 +: 32] = RO_VAL;

        repeat (2) @(negedge ACLK);
        chk("rst_awready", AWREADY, 1);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        ARESETn = 1;
        @(negedge ACLK);
        chk("rst_reg1", reg_out[63:32], 32'h0);
        chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

        // AW and W together
        pc = pulse_cnt[1];
        axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, resp);
        chk("t1_bresp", resp, 2'b00);
        repeat (2) @(negedge ACLK);
        chk("t1_pulse_cycles", 32'(pulse_cnt[1] - pc), 32'd1);
        chk("t1_model_reg1", m_regs[1], 32'hDEAD_BEEF);
        axi_read(32'h04, rd, resp);
        chk("t1_rdata", rd, 32'hDEAD_BEEF);
        chk("t1_rresp", resp, 2'b00);

        // W three cycles ahead of AW, single byte lane
        fork
            send_w(32'h0000_00AA, 4'b0001);
            begin
                repeat (3) @(negedge ACLK);
                chk("t2_bvalid_before_aw", BVALID, 0);
                chk("t2_wready_held", WREADY, 0);
                send_aw(32'h04);
            end
        join
        wait_b(resp);
        chk("t2_bresp", resp, 2'b00);
        axi_read(32'h04, rd, resp);
        chk("t2_rdata", rd, 32'hDEAD_BEAA);

        // out of range
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, resp);
        chk("t3_bresp", resp, 2'b10);
        axi_read(32'h40, rd, resp);
        chk("t3_rdata", rd, 32'h0);
        chk("t3_rresp", resp, 2'b10);
        chk("t3_reg1_kept", reg_out[63:32], 32'hDEAD_BEAA);

        // last register, partial strobes, ignored low address bits
        axi_write(32'h3C, 32'hCAFE_1234, 4'b1100, resp);
        chk("t3b_bresp", resp, 2'b00);
        axi_write(32'h3F, 32'h5555_F00D, 4'b0011, resp);
        chk("t3c_bresp", resp, 2'b00);
        axi_read(32'h3D, rd, resp);
        chk("t3c_rdata", rd, 32'hCAFE_F00D);

        // read-only register
        axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, resp);
        chk("t4_bresp", resp, 2'b10);
        axi_read(32'h08, rd, resp);
        chk("t4_rdata", rd, 32'h1234_5678);
        chk("t4_rresp", resp, 2'b00);
        chk("t4_reg_out2", reg_out[95:64], 32'h0);

        // zero strobe still pulses, data unchanged
        pc = pulse_cnt[1];
        axi_write(32'h04, 32'h0, 4'h0, resp);
        chk("t4b_bresp", resp, 2'b00);
        @(negedge ACLK);
        chk("t4b_pulse", 32'(pulse_cnt[1] - pc), 32'd1);
        chk("t4b_reg1", reg_out[63:32], 32'hDEAD_BEAA);

        // responses held under back-pressure
        fork
            send_aw(32'h10);
            send_w(32'h0BAD_F00D, 4'hF);
        join
        @(negedge ACLK);
        send_ar(32'h10);
        bsave = 32'(BRESP);
        rsave = RDATA;
        for (int i = 0; i < 5; i++) begin
            chk("t5_bvalid", BVALID, 1);
            chk("t5_bresp", BRESP, bsave);
            chk("t5_rvalid", RVALID, 1);
            chk("t5_rdata", RDATA, rsave);
            chk("t5_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
            @(negedge ACLK);
        end
        chk("t5_rdata_val", rsave, 32'h0BAD_F00D);
        wait_b(resp);
        chk("t5_bresp_final", resp, 2'b00);
        wait_r(rd, resp);
        chk("t5_rdata_final", rd, 32'h0BAD_F00D);

        // reset with an address held but no data
        send_aw(32'h0C);
        #2 ARESETn = 0;
        #2 ARESETn = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("t6_no_bvalid", BVALID, 0);
        end
        chk("t6_reg1_cleared", reg_out[63:32], 32'h0);
        axi_write(32'h0C, 32'h55AA_55AA, 4'hF, resp);
        chk("t6_bresp", resp, 2'b00);
        for (int i = 0; i < 4; i++) begin
            chk("t6_single_resp", BVALID, 0);
            @(negedge ACLK);
        end
        axi_read(32'h0C, rd, resp);
        chk("t6_rdata", rd, 32'h55AA_55AA);

        repeat (2) @(negedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
